// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared types and defaults for the add/sub issue controller.
//                Optional feature macro: ADDSUB_OVF_FLAG_EN (per-entry signed
//                overflow flag).
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 32;
    localparam int ADDSUB_DEPTH = 4;

    // Issue sequencer states: wait for a request, then one settle cycle.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } addsub_state_t;

    // One buffered result. The sum width follows the package default width.
    typedef struct packed {
        logic [ADDSUB_WIDTH-1:0] sum;
        logic                    mode;
`ifdef ADDSUB_OVF_FLAG_EN
        logic                    ovf;
`endif
    } addsub_result_t;

`ifdef ADDSUB_OVF_FLAG_EN
    // Signed overflow from operand/result sign bits. For subtraction the
    // effective second operand is -B, so the "same sign" test inverts.
    function automatic logic addsub_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb,
                                        input logic mode);
        logic same_sign;
        same_sign = mode ? (a_msb != b_msb) : (a_msb == b_msb);
        return same_sign && (s_msb != a_msb);
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/addsub_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_issue_ctrl_if
//  Description : Request, adder-side and result-side signal bundle for the
//                add/sub issue controller. OUT_OVF exists only when
//                ADDSUB_OVF_FLAG_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface addsub_issue_ctrl_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int DEPTH = ADDSUB_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Request side
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             IN_MODE;
    // Adder/subtractor side
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             MODE;
    logic [WIDTH-1:0] SUM;
    // Result side
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_SUM;
    logic             OUT_MODE;
`ifdef ADDSUB_OVF_FLAG_EN
    logic             OUT_OVF;
`endif
    logic [CNT_W-1:0] COUNT;

    // Controller view
    modport slave (
        input  IN_VALID, IN_A, IN_B, IN_MODE, SUM, OUT_READY,
        output IN_READY, A, B, MODE, OUT_VALID, OUT_SUM, OUT_MODE,
`ifdef ADDSUB_OVF_FLAG_EN
        output OUT_OVF,
`endif
        output COUNT
    );

    // Environment view (producer, adder model, consumer)
    modport master (
        output IN_VALID, IN_A, IN_B, IN_MODE, SUM, OUT_READY,
        input  IN_READY, A, B, MODE, OUT_VALID, OUT_SUM, OUT_MODE,
`ifdef ADDSUB_OVF_FLAG_EN
        input  OUT_OVF,
`endif
        input  COUNT
    );

endinterface
`default_nettype wire

// File: rtl/addsub_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_result_fifo
//  Description : Circular result FIFO with push/pop, occupancy count and a
//                head-entry output. Entry type is a parameter; with
//                ADDSUB_OVF_FLAG_EN the default entry carries an ovf bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_result_fifo
    import addsub_pkg::*;
#(
    parameter int  DEPTH = ADDSUB_DEPTH,
    parameter type T     = addsub_result_t
) (
    input  wire logic                         CLK,
    input  wire logic                         RST_N,
    input  wire logic                         push_i,
    input  wire T                             push_data_i,
    input  wire logic                         pop_i,
    output T                                  head_o,
    output logic [$clog2(DEPTH+1)-1:0]        count_o
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pops on an empty FIFO are dropped; pushes on a full one are dropped
    // as a safety net even though the controller never issues them.
    assign push_ok = push_i && (count_q != CNT_FULL);
    assign pop_ok  = pop_i  && (count_q != '0);

    // Next pointer/occupancy values; simultaneous push and pop cancel out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; storage clears so the head reads zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_issue_ctrl
//  Description : Issues requests to an external combinational add/sub unit,
//                samples SUM one cycle later and queues tagged results.
//                Optional feature macro: ADDSUB_OVF_FLAG_EN (signed overflow
//                flag stored per result and driven on OUT_OVF).
//                WIDTH must match the package default, which sizes the
//                stored result entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_issue_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int DEPTH = ADDSUB_DEPTH
) (
    input  wire logic           CLK,
    input  wire logic           RST_N,
    addsub_issue_ctrl_if.slave  bus
);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    addsub_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count;
    addsub_result_t   entry;
    addsub_result_t   head;

    // Ready uses registered occupancy only: a same-cycle pop grants no credit.
    assign bus.IN_READY = RST_N && (state_q == IDLE) && (count != CNT_FULL);
    assign accept       = bus.IN_VALID && bus.IN_READY;

    // Next-state logic: latch operands on acceptance, push after one settle cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.IN_A;
                    b_d     = bus.IN_B;
                    mode_d  = bus.IN_MODE;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; operands hold between requests.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.A    = a_q;
    assign bus.B    = b_q;
    assign bus.MODE = mode_q;

    // Result entry built from the external SUM and the held operands.
    always_comb begin
        entry      = '0;
        entry.sum  = bus.SUM;
        entry.mode = mode_q;
`ifdef ADDSUB_OVF_FLAG_EN
        entry.ovf  = addsub_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                bus.SUM[WIDTH-1], mode_q);
`endif
    end

    assign pop = bus.OUT_READY && bus.OUT_VALID;

    addsub_result_fifo #(
        .DEPTH (DEPTH),
        .T     (addsub_result_t)
    ) u_fifo (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .push_i      (push),
        .push_data_i (entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.OUT_VALID = (count != '0);
    assign bus.OUT_SUM   = head.sum;
    assign bus.OUT_MODE  = head.mode;
`ifdef ADDSUB_OVF_FLAG_EN
    assign bus.OUT_OVF   = head.ovf;
`endif
    assign bus.COUNT     = count;

endmodule
`default_nettype wire

// File: tb/tb_addsub_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_issue_ctrl
//  Description : Scoreboard bench for addsub_issue_ctrl: directed scenarios
//                plus randomized operations against an arithmetic model.
//                Honours ADDSUB_OVF_FLAG_EN for the overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_issue_ctrl;
    import addsub_pkg::*;

    localparam int W = 32;
    localparam int D = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    addsub_issue_ctrl_if #(.WIDTH(W), .DEPTH(D)) bus();

    // External combinational adder/subtractor
    assign bus.SUM = bus.MODE ? (bus.A - bus.B) : (bus.A + bus.B);

    addsub_issue_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         mode;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 1;     // 0: stall, 1: always ready, 2: random
    bit   pop_once = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic, then wrap to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t   e;
        longint sa, sbv, r, smax, smin;
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        r    = m ? (sa - sbv) : (sa + sbv);
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -smax - 1;
        e.sum  = r[W-1:0];
        e.mode = m;
        e.ovf  = (r > smax) || (r < smin);
        return e;
    endfunction

    task automatic wait_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge CLK);
            if (bus.IN_READY) begin
                sb.push_back(model(a, b, m));
                @(posedge CLK);
                #1;
                bus.IN_VALID = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got no IN_READY required IN_READY=1");
            bus.IN_VALID = 1'b0;
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b1;
        bus.IN_A     = a;
        bus.IN_B     = b;
        bus.IN_MODE  = m;
        wait_accept(a, b, m);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Consumer: drives OUT_READY shortly after each rising edge.
    initial begin
        bus.OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (pop_once) begin
                bus.OUT_READY = 1'b1;
                pop_once = 1'b0;
            end else begin
                case (rdy_mode)
                    0:       bus.OUT_READY = 1'b0;
                    1:       bus.OUT_READY = 1'b1;
                    default: bus.OUT_READY = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // Monitor: compares each popped head with the scoreboard and checks
    // that a stalled head stays put.
    initial begin
        logic         hold = 1'b0;
        logic [W-1:0] p_sum = '0;
        logic         p_mode = 1'b0;
        exp_t         e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", bus.OUT_VALID, 1'b1);
                    chk("stall_sum",   bus.OUT_SUM,   p_sum);
                    chk("stall_mode",  bus.OUT_MODE,  p_mode);
                end
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got sum %0h required no output", bus.OUT_SUM);
                    end else begin
                        e = sb.pop_front();
                        chk("out_sum",  bus.OUT_SUM,  e.sum);
                        chk("out_mode", bus.OUT_MODE, e.mode);
`ifdef ADDSUB_OVF_FLAG_EN
                        chk("out_ovf",  bus.OUT_OVF,  e.ovf);
`endif
                    end
                end
                hold   = bus.OUT_VALID && !bus.OUT_READY;
                p_sum  = bus.OUT_SUM;
                p_mode = bus.OUT_MODE;
            end
        end
    end

    // Main stimulus
    initial begin
        bus.IN_VALID = 1'b1;
        bus.IN_A     = 32'h1234_5678;
        bus.IN_B     = 32'h0000_0042;
        bus.IN_MODE  = 1'b0;
        RST_N        = 1'b0;

        // Reset held with a pending request
        repeat (3) @(negedge CLK);
        chk("rst_in_ready",  bus.IN_READY,  1'b0);
        chk("rst_out_valid", bus.OUT_VALID, 1'b0);
        chk("rst_a",         bus.A,         '0);
        chk("rst_b",         bus.B,         '0);
        chk("rst_mode",      bus.MODE,      1'b0);
        chk("rst_count",     bus.COUNT,     '0);
        chk("rst_out_sum",   bus.OUT_SUM,   '0);
        bus.IN_VALID = 1'b0;
        RST_N        = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", bus.IN_READY, 1'b1);

        // Single add with latency checks
        issue(32'd15, 32'd7, 1'b0);
        @(negedge CLK);
        chk("lat_a",         bus.A,         32'd15);
        chk("lat_b",         bus.B,         32'd7);
        chk("lat_mode",      bus.MODE,      1'b0);
        chk("lat_not_valid", bus.OUT_VALID, 1'b0);
        @(negedge CLK);
        chk("lat_valid",     bus.OUT_VALID, 1'b1);
        chk("lat_sum",       bus.OUT_SUM,   32'd22);
        chk("lat_count1",    bus.COUNT,     3'd1);
        @(negedge CLK);
        chk("lat_count0",    bus.COUNT,     3'd0);

        // Subtractions
        issue(32'd12, 32'd10, 1'b1);
        issue(32'd5,  32'd9,  1'b1);
        drain();

        // Back-pressure fill and single pop
        rdy_mode = 0;
        issue(32'd10, 32'd1, 1'b0);
        issue(32'd20, 32'd3, 1'b1);
        issue(32'd0,  32'd0, 1'b0);
        issue(32'd9,  32'd9, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        chk("full_count", bus.COUNT,    3'd4);
        chk("full_ready", bus.IN_READY, 1'b0);
        bus.IN_VALID = 1'b1;
        bus.IN_A     = 32'd3;
        bus.IN_B     = 32'd4;
        bus.IN_MODE  = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("held_ready", bus.IN_READY, 1'b0);
            chk("held_count", bus.COUNT,    3'd4);
        end
        pop_once = 1'b1;
        @(negedge CLK);
        chk("pop_ready_same", bus.IN_READY, 1'b0);
        @(negedge CLK);
        chk("pop_count", bus.COUNT,    3'd3);
        chk("pop_ready", bus.IN_READY, 1'b1);
        sb.push_back(model(32'd3, 32'd4, 1'b0));
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        rdy_mode = 1;
        drain();

        // Overflow corners
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        issue(32'd15,        32'd7,         1'b0);
        drain();

        // Reset while an op is in flight with two results queued
        rdy_mode = 0;
        repeat (2) @(posedge CLK);
        issue(32'd1, 32'd2, 1'b0);
        issue(32'd3, 32'd4, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_rst_count", bus.COUNT, 3'd2);
        issue(32'd5, 32'd6, 1'b0);
        RST_N = 1'b0;
        sb.delete();
        @(negedge CLK);
        chk("midrst_count", bus.COUNT,     3'd0);
        chk("midrst_valid", bus.OUT_VALID, 1'b0);
        chk("midrst_ready", bus.IN_READY,  1'b0);
        rdy_mode = 1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        chk("postrst_count", bus.COUNT,     3'd0);
        chk("postrst_valid", bus.OUT_VALID, 1'b0);

        // Randomized traffic with random consumer stalls
        rdy_mode = 2;
        for (int n = 0; n < 60; n++) begin
            issue(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
        end
        rdy_mode = 1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_issue_ctrl.md
# addsub_issue_ctrl

Sequencing stage directly upstream of the 32-bit combinational adder/subtractor. It accepts operation requests over a valid/ready handshake and drives `A`, `B` and `MODE` into the adder/subtractor. One cycle later it samples `SUM`, tags it with the operation mode and a signed-overflow flag, and buffers the result in a small FIFO drained by a valid/ready consumer. It decouples producers and consumers from the adder's settle time and gives the datapath back-pressure.

## Interface
- `WIDTH`, 32, operand/result width (≥2)
- `DEPTH`, 4, result FIFO entries (power of 2, ≥2)
- `CLK`  in  1  single clock, rising-edge
- `RST_N`  in  1  asynchronous active-low reset
- `IN_VALID`  in  1  request valid
- `IN_READY`  out  1  request accepted when high with `IN_VALID`
- `IN_A`  in  WIDTH  operand A
- `IN_B`  in  WIDTH  operand B
- `IN_MODE`  in  1  0 = add, 1 = subtract
- `A`  out  WIDTH  registered operand A to adder/subtractor
- `B`  out  WIDTH  registered operand B to adder/subtractor
- `MODE`  out  1  registered mode to adder/subtractor
- `SUM`  in  WIDTH  adder/subtractor result, valid one cycle after `A`/`B`/`MODE` change
- `OUT_VALID`  out  1  FIFO head valid
- `OUT_READY`  in  1  consumer pops head when high with `OUT_VALID`
- `OUT_SUM`  out  WIDTH  head result
- `OUT_MODE`  out  1  head mode
- `OUT_OVF`  out  1  head signed overflow (only with `ADDSUB_OVF_FLAG_EN`)
- `COUNT`  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- FSM has two states:
  - IDLE: on `IN_VALID && IN_READY`, register `IN_A`/`IN_B`/`IN_MODE` into `A`/`B`/`MODE` and go to EXEC.
  - EXEC: one cycle. At the next edge, push {`SUM`, `MODE`, ovf} into the FIFO and return to IDLE.
- `IN_READY = RST_N && state==IDLE && COUNT != DEPTH`. This uses the registered `COUNT`; there is no pop-through credit.
- `A`/`B`/`MODE` hold their last values when idle and change only on acceptance.
- Results leave strictly in acceptance order.
- FIFO:
  - circular, read/write pointers with wrap at `DEPTH`;
  - `OUT_*` driven from the head entry;
  - push and pop in the same cycle leave `COUNT` unchanged;
  - a pop while empty is ignored;
  - a push is never issued while full, guaranteed by `IN_READY`.
- All arithmetic is modulo 2^WIDTH. The block never recomputes the sum; `SUM` is the sole source.

## Timing
- Reset state (async assert, sync release): state IDLE, `A`=`B`=0, `MODE`=0, FIFO pointers 0, `COUNT`=0, `OUT_VALID`=0, `OUT_SUM`=0, `OUT_MODE`=0, `OUT_OVF`=0, `IN_READY`=0.
- Latency from acceptance to output:
  - accept at edge k;
  - `A`/`B`/`MODE` valid after edge k;
  - `SUM` sampled at edge k+1;
  - `OUT_VALID`=1 after edge k+1 if the FIFO was empty.
- Throughput: one op per 2 cycles.
- Reset mid-EXEC discards the in-flight op and flushes the FIFO. No partial result is pushed.
- `OUT_VALID` deasserts only by pop or reset. `OUT_*` are stable while `OUT_VALID && !OUT_READY`.

## Configuration
- `ADDSUB_OVF_FLAG_EN` defined:
  - Overflow flag stored per entry and driven on `OUT_OVF`.
  - Add: ovf = (A[msb]==B[msb]) && (SUM[msb]!=A[msb]).
  - Subtract: ovf = (A[msb]!=B[msb]) && (SUM[msb]!=A[msb]).
  - Evaluated on the held `A`/`B` and sampled `SUM`.
- Not defined: `OUT_OVF` port absent, FIFO entries carry only sum and mode.

## Structure
- Package `addsub_pkg` holds:
  - state enum `addsub_state_t` {IDLE, EXEC};
  - result struct `addsub_result_t` {sum, mode, ovf (macro-gated)};
  - default `WIDTH`/`DEPTH` localparams.
- Sub-module `addsub_result_fifo`, parameterised on `DEPTH` and the entry type: push/pop/count/head, async active-low reset.

## Test plan
- Reset: hold `RST_N`=0 with `IN_VALID`=1 → `IN_READY`=0, `OUT_VALID`=0, `A`=`B`=0, `COUNT`=0. After release → `IN_READY`=1.
- Add A=15, B=7, MODE=0, `OUT_READY`=1 → two edges later `OUT_VALID`=1, `OUT_SUM`=22, `OUT_MODE`=0. Popped next edge, `COUNT` back to 0.
- Subtract 12−10 → `OUT_SUM`=2. Subtract 5−9 → `OUT_SUM`=32'hFFFF_FFFC, `OUT_MODE`=1.
- Back-pressure with `OUT_READY`=0, issue 4 ops (10+1, 20−3, 0+0, 9−9):
  - `COUNT`=4, `IN_READY`=0, 5th request held;
  - pop one → `IN_READY`=1 the next cycle;
  - outputs in order: 11, 17, 0, 0.
- With `ADDSUB_OVF_FLAG_EN`:
  - 32'h7FFF_FFFF+1 → `OUT_SUM`=32'h8000_0000, `OUT_OVF`=1;
  - 32'h8000_0000−1 → `OUT_OVF`=1;
  - 15+7 → `OUT_OVF`=0.
- Reset asserted during EXEC with 2 entries queued → after release `COUNT`=0, `OUT_VALID`=0, and no result for the in-flight op ever appears.
